// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// store size codes, grant identifiers and the default watchdog limit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_busy(input arb_state_t s);
    return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Watchdog for an in-flight memory access: 8-bit saturating counter with
// clear and enable, and a flag that latches once the limit is reached.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic flag
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt;

  // Count waiting cycles; the flag sets on the edge where the count hits LIMIT and stays set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt  <= 8'd0;
      flag <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= 8'd0;
      end else if (en && (cnt != LIMIT)) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= cnt;
      end
      flag <= flag || (!clr && en && (cnt == LIMIT - 8'd1));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage data accesses onto one memory port.
// Define MEM_ARB_RR_EN for round-robin grant; otherwise data beats fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  arb_state_t state;
  logic       d_any;
  logic       grant_i;
  logic       grant_d;

  assign d_any = d_read || d_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On contention pick whichever side was not served last.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_any && i_req) begin
      grant_d = (last_grant == GRANT_I);
      grant_i = (last_grant == GRANT_D);
    end else begin
      grant_d = d_any;
      grant_i = i_req;
    end
  end

  // Remember the most recent grant for the next contention.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_grant <= GRANT_D;
    end else if ((state == ARB_IDLE) && grant_d) begin
      last_grant <= GRANT_D;
    end else if ((state == ARB_IDLE) && grant_i) begin
      last_grant <= GRANT_I;
    end else begin
      last_grant <= last_grant;
    end
  end
`else
  // Fixed priority: data side always wins.
  always_comb begin
    grant_d = d_any;
    grant_i = i_req && !d_any;
  end
`endif

  // Grant/sequencing FSM; every mem_* output is registered here and held while busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= SZ_WORD;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state     <= ARB_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_size  <= d_size;
          end else if (grant_i) begin
            state    <= ARB_BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            mem_size <= SZ_WORD;
          end else begin
            mem_req <= 1'b0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          // The ack cycle never re-grants, so accesses are at least two cycles apart.
          if (mem_ack) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign i_stall = i_req && !((state == ARB_BUSY_I) && mem_ack);
  assign d_stall = d_any && !((state == ARB_BUSY_D) && mem_ack);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  ((state == ARB_IDLE) && (grant_i || grant_d)),
    .en   (is_busy(state) && !mem_ack),
    .flag (err_timeout)
  );

endmodule
